bfp_psum_accumulator: RTL



---
 rtl/bfp_pkg.sv | 31 +++
 rtl/bfp_psum_accumulator_out_reg.sv | 59 +++++
 rtl/bfp_psum_accumulator.sv | 134 +++++++++++++
 3 files changed

// File: rtl/bfp_pkg.sv
// Shared BFP datapath constants, exponent types and the saturating adder
// used by the partial-sum accumulator.
package bfp_pkg;

    localparam int BFP_MANT_W = 8;
    localparam int BFP_PSUM_W = 2 * BFP_MANT_W + 2;
    localparam int BFP_EXP_W  = 8;

    // Widest accumulator the saturating adder supports (strictly less than SAT_W).
    localparam int SAT_W = 64;

    typedef logic signed [BFP_EXP_W-1:0] bfp_exp_t;
    typedef logic signed [BFP_EXP_W:0]   bfp_exp_sum_t;

    // Returns {ovf, sum}; sum is clamped to 2^width-1 when it does not fit.
    function automatic logic [SAT_W:0] sat_add_u(
        input logic [SAT_W-1:0] a,
        input logic [SAT_W-1:0] b,
        input int unsigned      width
    );
        logic [SAT_W:0] sum;
        logic [SAT_W:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = ({{SAT_W{1'b0}}, 1'b1} << width) - {{SAT_W{1'b0}}, 1'b1};
        if (sum > lim) begin
            return {1'b1, lim[SAT_W-1:0]};
        end
        return {1'b0, sum[SAT_W-1:0]};
    endfunction

endpackage

// File: rtl/bfp_psum_accumulator_out_reg.sv
// Single-entry valid/ready output register; a load may coincide with a
// drain so a result can be emitted every cycle.
module bfp_out_reg #(
    parameter int DAT_W = 32,
    parameter int EXP_W = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [DAT_W-1:0] ld_dat,
    input  logic [EXP_W-1:0] ld_exp,
    input  logic             ld_ovf,
    input  logic             out_rdy,
    output logic             out_vld,
    output logic [DAT_W-1:0] out_dat,
    output logic [EXP_W-1:0] out_exp,
    output logic             out_ovf
);

    logic             vld_q, vld_d;
    logic [DAT_W-1:0] dat_q, dat_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        exp_d = exp_q;
        ovf_d = ovf_q;
        if (load) begin
            vld_d = 1'b1;
            dat_d = ld_dat;
            exp_d = ld_exp;
            ovf_d = ld_ovf;
        end else if (out_rdy) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            dat_q <= '0;
            exp_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
            exp_q <= exp_d;
            ovf_q <= ovf_d;
        end
    end

    assign out_vld = vld_q;
    assign out_dat = dat_q;
    assign out_exp = exp_q;
    assign out_ovf = ovf_q;

endmodule

// File: rtl/bfp_psum_accumulator.sv
// Accumulates cfg_len PE partial-sum beats into one saturated mantissa and
// tags it with the combined block exponent.
module bfp_psum_accumulator
    import bfp_pkg::*;
#(
    parameter int IN_WIDTH  = 18,
    parameter int ACC_WIDTH = 32,
    parameter int EXP_WIDTH = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CNT_WIDTH-1:0] cfg_len,
    input  logic [EXP_WIDTH-1:0] exp_a,
    input  logic [EXP_WIDTH-1:0] exp_b,
    input  logic                 flush,
    input  logic                 in_vld,
    input  logic [IN_WIDTH-1:0]  in_dat,
    output logic                 in_rdy,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic [ACC_WIDTH-1:0] out_dat,
    output logic [EXP_WIDTH:0]   out_exp,
    output logic                 out_ovf,
    output logic                 busy
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] len_q, len_d;
    logic [EXP_WIDTH:0]   exp_sum_q, exp_sum_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 govf_q, govf_d;

    logic [CNT_WIDTH-1:0] len_eff;
    logic [EXP_WIDTH:0]   exp_new;
    logic                 idle;
    logic                 final_beat;
    logic                 beat;
    logic [SAT_W:0]       add_r;
    logic [ACC_WIDTH-1:0] add_sum;
    logic                 add_ovf;

    logic                 res_load;
    logic [ACC_WIDTH-1:0] res_dat;
    logic [EXP_WIDTH:0]   res_exp;
    logic                 res_ovf;

    assign len_eff = (cfg_len == '0) ? CNT_WIDTH'(1) : cfg_len;
    assign exp_new = {exp_a[EXP_WIDTH-1], exp_a} + {exp_b[EXP_WIDTH-1], exp_b};
    assign idle    = (cnt_q == '0);

    assign final_beat = idle ? (len_eff == CNT_WIDTH'(1))
                             : (cnt_q + CNT_WIDTH'(1) == len_q);

    // Only a group-completing beat needs a free output slot.
    assign in_rdy = !(final_beat && out_vld && !out_rdy);
    assign beat   = in_vld && in_rdy && !flush;

    assign add_r   = sat_add_u(SAT_W'(acc_q), SAT_W'(in_dat), ACC_WIDTH);
    assign add_sum = add_r[ACC_WIDTH-1:0];
    assign add_ovf = add_r[SAT_W] | (|add_r[SAT_W-1:ACC_WIDTH]);

    always_comb begin
        cnt_d     = cnt_q;
        len_d     = len_q;
        exp_sum_d = exp_sum_q;
        acc_d     = acc_q;
        govf_d    = govf_q;
        res_load  = 1'b0;
        res_dat   = acc_q;
        res_exp   = exp_sum_q;
        res_ovf   = govf_q;
        if (flush) begin
            cnt_d  = '0;
            acc_d  = '0;
            govf_d = 1'b0;
        end else if (beat) begin
            if (idle) begin
                len_d     = len_eff;
                exp_sum_d = exp_new;
                acc_d     = ACC_WIDTH'(in_dat);
                govf_d    = 1'b0;
                cnt_d     = CNT_WIDTH'(1);
            end else begin
                acc_d  = add_sum;
                govf_d = govf_q | add_ovf;
                cnt_d  = cnt_q + CNT_WIDTH'(1);
            end
            if (final_beat) begin
                cnt_d    = '0;
                res_load = 1'b1;
                res_dat  = acc_d;
                res_exp  = exp_sum_d;
                res_ovf  = govf_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            len_q     <= '0;
            exp_sum_q <= '0;
            acc_q     <= '0;
            govf_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            exp_sum_q <= exp_sum_d;
            acc_q     <= acc_d;
            govf_q    <= govf_d;
        end
    end

    assign busy = !idle;

    bfp_out_reg #(
        .DAT_W(ACC_WIDTH),
        .EXP_W(EXP_WIDTH + 1)
    ) u_out_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (res_load),
        .ld_dat  (res_dat),
        .ld_exp  (res_exp),
        .ld_ovf  (res_ovf),
        .out_rdy (out_rdy),
        .out_vld (out_vld),
        .out_dat (out_dat),
        .out_exp (out_exp),
        .out_ovf (out_ovf)
    );

endmodule
